// File: rtl/mrd_rdx2345_pkg.sv
// Beat bundle exchanged between the rotating data memories and the radix-2/3/4/5 engine.
package mrd_rdx2345_pkg;

   localparam int FSM_W       = 3;
   localparam int D_W         = 16;
   localparam int BANK_IDX_W  = 3;
   localparam int BANK_ADDR_W = 10;
   localparam int TW_SEL_W    = 2;
   localparam int TW_STEP_W   = 10;
   localparam int TW_EXP_W    = 4;

   typedef struct packed {
      logic [FSM_W-1:0]        fsm;
      logic                    valid;
      logic signed [D_W-1:0]   d_real;
      logic signed [D_W-1:0]   d_imag;
      logic [BANK_IDX_W-1:0]   bank_index;
      logic [BANK_ADDR_W-1:0]  bank_addr;
      logic [TW_SEL_W-1:0]     tw_ROM_sel;
      logic [TW_STEP_W-1:0]    tw_ROM_addr_step;
      logic [TW_EXP_W-1:0]     tw_ROM_exp_ceil;
      logic [TW_EXP_W-1:0]     tw_ROM_exp_time;
   } mrd_rdx2345_t;

endpackage

// File: rtl/mrd_rdx2345_reg.sv
// One-cycle register of a full beat bundle; every field clears on reset.
module mrd_rdx2345_reg
   import mrd_rdx2345_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  mrd_rdx2345_t din,
   output mrd_rdx2345_t dout
);

   mrd_rdx2345_t data_d;
   mrd_rdx2345_t data_q;

   always_comb begin
      data_d = din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign dout = data_q;

endmodule

// File: rtl/mrd_switch_nbank.sv
// Rotating N-bank switch: engine reads memory ptr and writes memory ptr+1;
// role rotation requests are deferred until both selected paths are idle.
module mrd_switch_nbank
   import mrd_rdx2345_pkg::*;
#(
   parameter int NUM_MEM = 2,
   parameter int PTR_W   = $clog2(NUM_MEM)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sw_req,
   input  mrd_rdx2345_t     from_mem [NUM_MEM],
   output mrd_rdx2345_t     to_mem [NUM_MEM],
   input  mrd_rdx2345_t     from_rdx2345,
   output mrd_rdx2345_t     to_rdx2345,
   output logic [PTR_W-1:0] ptr,
   output logic             sw_pending,
   output logic             sw_done,
   output logic             sw_drop
);

   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_MEM - 1);

   logic [PTR_W-1:0] ptr_q, ptr_d, wr_idx;
   logic             sw_pending_q, sw_pending_d;
   logic             sw_done_q, sw_done_d;
   logic             sw_drop_q, sw_drop_d;
   logic             idle, req_eff;
   mrd_rdx2345_t     rdx_d;
   mrd_rdx2345_t     mem_d [NUM_MEM];

   // Routing is steered by the pre-edge pointer, so a rotation shows up one edge later.
   always_comb begin
      wr_idx = (ptr_q == LAST_IDX) ? '0 : ptr_q + PTR_W'(1);
      rdx_d  = from_mem[ptr_q];
      for (int k = 0; k < NUM_MEM; k++) begin
         mem_d[k] = (PTR_W'(k) == wr_idx) ? from_rdx2345 : '0;
      end
   end

   always_comb begin
      idle         = !from_mem[ptr_q].valid && !from_rdx2345.valid;
      req_eff      = sw_pending_q | sw_req;
      ptr_d        = ptr_q;
      sw_pending_d = sw_pending_q;
      sw_done_d    = 1'b0;
      sw_drop_d    = sw_req & sw_pending_q;
      // Rotating only in an idle cycle keeps every beat within a single memory.
      if (req_eff) begin
         if (idle) begin
            ptr_d        = wr_idx;
            sw_pending_d = 1'b0;
            sw_done_d    = 1'b1;
         end else begin
            sw_pending_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q        <= '0;
         sw_pending_q <= 1'b0;
         sw_done_q    <= 1'b0;
         sw_drop_q    <= 1'b0;
      end else begin
         ptr_q        <= ptr_d;
         sw_pending_q <= sw_pending_d;
         sw_done_q    <= sw_done_d;
         sw_drop_q    <= sw_drop_d;
      end
   end

   mrd_rdx2345_reg u_rdx_reg (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (rdx_d),
      .dout (to_rdx2345)
   );

   for (genvar g = 0; g < NUM_MEM; g++) begin : g_mem_reg
      mrd_rdx2345_reg u_mem_reg (
         .clk  (clk),
         .rst_n(rst_n),
         .din  (mem_d[g]),
         .dout (to_mem[g])
      );
   end

   assign ptr        = ptr_q;
   assign sw_pending = sw_pending_q;
   assign sw_done    = sw_done_q;
   assign sw_drop    = sw_drop_q;

endmodule

// File: tb/tb_mrd_switch_nbank.sv
// Bench for mrd_switch_nbank: a 2-bank and a 3-bank instance share stimulus
// and are compared every cycle against a behavioural model.
module tb_mrd_switch_nbank;
   import mrd_rdx2345_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic sw_req = 1'b0;
   mrd_rdx2345_t fm2 [2];
   mrd_rdx2345_t fm3 [3];
   mrd_rdx2345_t fr;
   mrd_rdx2345_t t2_mem [2];
   mrd_rdx2345_t t3_mem [3];
   mrd_rdx2345_t t2_rdx, t3_rdx;
   logic [0:0] p2;
   logic [1:0] p3;
   logic pend2, done2, drop2, pend3, done3, drop3;

   int checks = 0;
   int failures = 0;

   int           m_ptr [2];
   bit           m_pend [2];
   mrd_rdx2345_t e_rdx [2];
   mrd_rdx2345_t e_mem [2][3];
   bit           e_done [2];
   bit           e_drop [2];

   always #5 clk = ~clk;

   mrd_switch_nbank #(.NUM_MEM(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .sw_req(sw_req),
      .from_mem(fm2), .to_mem(t2_mem),
      .from_rdx2345(fr), .to_rdx2345(t2_rdx),
      .ptr(p2), .sw_pending(pend2), .sw_done(done2), .sw_drop(drop2)
   );

   mrd_switch_nbank #(.NUM_MEM(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .sw_req(sw_req),
      .from_mem(fm3), .to_mem(t3_mem),
      .from_rdx2345(fr), .to_rdx2345(t3_rdx),
      .ptr(p3), .sw_pending(pend3), .sw_done(done3), .sw_drop(drop3)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic mrd_rdx2345_t rand_beat(input bit v);
      logic [95:0]  r;
      mrd_rdx2345_t b;
      r = {$urandom(), $urandom(), $urandom()};
      b = mrd_rdx2345_t'(r[$bits(mrd_rdx2345_t)-1:0]);
      b.valid = v;
      return b;
   endfunction

   task automatic set_inputs(input bit req, input logic [2:0] mask, input bit rv);
      sw_req = req;
      for (int k = 0; k < 3; k++) begin
         fm3[k] = rand_beat(mask[k]);
         if (k < 2) fm2[k] = fm3[k];
      end
      fr = rand_beat(rv);
   endtask

   // Model: bank ptr feeds the engine, bank (ptr+1)%n receives results,
   // a request waits for a cycle where both selected paths carry no valid.
   task automatic step();
      for (int i = 0; i < 2; i++) begin
         int n;
         int rd;
         int wr;
         n  = (i == 0) ? 2 : 3;
         rd = m_ptr[i];
         wr = (m_ptr[i] + 1) % n;
         e_rdx[i] = fm3[rd];
         for (int k = 0; k < 3; k++) e_mem[i][k] = (k == wr) ? fr : '0;
         e_drop[i] = sw_req && m_pend[i];
         e_done[i] = 1'b0;
         if (sw_req || m_pend[i]) begin
            if (!fm3[rd].valid && !fr.valid) begin
               m_ptr[i]  = (m_ptr[i] + 1) % n;
               m_pend[i] = 1'b0;
               e_done[i] = 1'b1;
            end else begin
               m_pend[i] = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("d2_rdx", t2_rdx, e_rdx[0]);
      for (int k = 0; k < 2; k++) chk("d2_mem", t2_mem[k], e_mem[0][k]);
      chk("d2_ptr", p2, m_ptr[0]);
      chk("d2_pend", pend2, m_pend[0]);
      chk("d2_done", done2, e_done[0]);
      chk("d2_drop", drop2, e_drop[0]);
      chk("d3_rdx", t3_rdx, e_rdx[1]);
      for (int k = 0; k < 3; k++) chk("d3_mem", t3_mem[k], e_mem[1][k]);
      chk("d3_ptr", p3, m_ptr[1]);
      chk("d3_pend", pend3, m_pend[1]);
      chk("d3_done", done3, e_done[1]);
      chk("d3_drop", drop3, e_drop[1]);
   endtask

   task automatic cyc(input bit req, input logic [2:0] mask, input bit rv);
      set_inputs(req, mask, rv);
      step();
   endtask

   task automatic reset_check(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_rdx2"}, t2_rdx, '0);
      chk({tag, "_rdx3"}, t3_rdx, '0);
      for (int k = 0; k < 2; k++) chk({tag, "_mem2"}, t2_mem[k], '0);
      for (int k = 0; k < 3; k++) chk({tag, "_mem3"}, t3_mem[k], '0);
      chk({tag, "_ctl2"}, {p2, pend2, done2, drop2}, '0);
      chk({tag, "_ctl3"}, {p3, pend3, done3, drop3}, '0);
      m_ptr  = '{0, 0};
      m_pend = '{1'b0, 1'b0};
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      set_inputs(1'b0, 3'b111, 1'b1);
      #3;
      reset_check("rst0");

      // Engine reads mem0 after reset
      set_inputs(1'b0, 3'b001, 1'b0);
      fm3[0].d_real = 16'h0123;
      fm2[0].d_real = 16'h0123;
      step();
      chk("r031_dreal", t2_rdx.d_real, 16'h0123);
      chk("r031_mem0", t2_mem[0], '0);

      // Idle request rotates at once; results then go to mem0
      cyc(1'b1, 3'b000, 1'b0);
      chk("r032_ptr", p2, 1);
      chk("r032_done", done2, 1);
      cyc(1'b0, 3'b000, 1'b1);
      chk("r032_mem0_vld", t2_mem[0].valid, 1);
      chk("r032_mem1", t2_mem[1], '0);

      // Requests during an 8-beat burst: deferred, second one dropped
      for (int b = 0; b < 8; b++) begin
         cyc((b == 2) || (b == 5), 3'b111, 1'b1);
         if (b == 5) chk("r034_drop", drop2, 1);
      end
      chk("r033_pend", pend2, 1);
      chk("r033_ptr_hold", p2, 1);
      cyc(1'b0, 3'b000, 1'b0);
      chk("r033_rot_ptr", p2, 0);
      chk("r033_rot_done", done2, 1);
      cyc(1'b0, 3'b000, 1'b0);
      chk("r034_once", p2, 0);

      // Three-bank walk
      reset_check("rst1");
      for (int r = 0; r < 3; r++) begin
         cyc(1'b1, 3'b000, 1'b0);
         chk("r035_ptr", p3, (r + 1) % 3);
         cyc(1'b0, 3'b000, 1'b1);
         chk("r035_wr", t3_mem[(r + 2) % 3].valid, 1);
      end

      repeat (300) cyc($urandom_range(0, 7) == 0, 3'($urandom()), $urandom_range(0, 2) == 0);

      // Reset while a rotation is pending on bank 2
      for (int g = 0; g < 6 && m_ptr[1] != 2; g++) begin
         cyc(1'b1, 3'b000, 1'b0);
         cyc(1'b0, 3'b000, 1'b0);
      end
      cyc(1'b1, 3'b111, 1'b1);
      chk("r036_pre_ptr", p3, 2);
      chk("r036_pre_pend", pend3, 1);
      reset_check("rst2");
      cyc(1'b0, 3'b000, 1'b0);
      chk("r036_nodone", done3, 0);
      chk("r036_ptr0", p3, 0);
      cyc(1'b0, 3'b000, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
